// File: rtl/counter_pkg.sv
// Shared definitions for the range-bounded counters.
// Provides mode and direction encodings plus an unsigned clamp helper.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Unsigned min(a, b). Operands are zero-extended to 32 bits by the caller,
  // so counters using it must stay at or below 31 bits.
  function automatic logic [31:0] clamp_min(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/step_unit.sv
// Combinational next-value logic for one counter step inside the range 0..limit.
// Ports:
//   c_i     - base count, already clamped to limit (width+1 bits)
//   s_i     - step magnitude, already clamped to limit+1 (width+1 bits)
//   limit_i - top of range, inclusive
//   up_i    - direction (DIR_UP / DIR_DOWN)
//   sat_i   - mode (MODE_SAT / MODE_WRAP)
//   next_o  - count after the step
//   ovf_o   - step left the range (wrapped or saturated)
module step_unit
  import counter_pkg::*;
#(
  parameter int unsigned width = 5
) (
  input  logic [width:0]   c_i,
  input  logic [width:0]   s_i,
  input  logic [width-1:0] limit_i,
  input  logic             up_i,
  input  logic             sat_i,
  output logic [width-1:0] next_o,
  output logic             ovf_o
);

  localparam int unsigned CW = width + 1;

  logic [width:0] limit_ext;
  logic [width:0] range_sz;
  logic [width:0] up_sum;

  // All intermediates fit in width+1 bits: c <= limit and s <= limit+1.
  assign limit_ext = CW'(limit_i);
  assign range_sz  = limit_ext + CW'(1);
  assign up_sum    = c_i + s_i;

  always_comb begin
    next_o = c_i[width-1:0];
    ovf_o  = 1'b0;
    if (up_i == DIR_UP) begin
      if (up_sum <= limit_ext) begin
        next_o = up_sum[width-1:0];
      end else begin
        ovf_o = 1'b1;
        if (sat_i == MODE_SAT) begin
          next_o = limit_i;
        end else begin
          next_o = width'(up_sum - range_sz);
        end
      end
    end else begin
      if (s_i <= c_i) begin
        next_o = width'(c_i - s_i);
      end else begin
        ovf_o = 1'b1;
        if (sat_i == MODE_SAT) begin
          next_o = '0;
        end else begin
          next_o = width'(c_i + range_sz - s_i);
        end
      end
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Loadable up/down counter with programmable step and range 0..limit,
// wrap or saturate at the range ends.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   load, cnt_in   - load cnt_in clamped to limit (beats enab)
//   enab           - apply one step
//   up, sat, step  - direction, saturate mode, step magnitude (0 = hold)
//   limit          - inclusive top of range
//   cnt_out        - registered count
//   evt            - registered pulse: the last step left the range
//   ovf            - sticky copy of evt, cleared by rst or load
//   at_end         - combinational: count sits at the end it is heading for
// step_w must not exceed width; width must not exceed 31.
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned width  = 5,
  parameter int unsigned step_w = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              enab,
  input  logic              up,
  input  logic              sat,
  input  logic [step_w-1:0] step,
  input  logic [width-1:0]  limit,
  input  logic [width-1:0]  cnt_in,
  output logic [width-1:0]  cnt_out,
  output logic              evt,
  output logic              ovf,
  output logic              at_end
);

  localparam int unsigned CW = width + 1;

  logic [width-1:0] cnt_q, cnt_d;
  logic             evt_q, evt_d;
  logic             ovf_q, ovf_d;

  logic [width:0]   base_c;
  logic [width:0]   limit_p1;
  logic [width:0]   step_s;
  logic [width-1:0] step_next;
  logic             step_ovf;

  // A limit lowered below the current count is absorbed by clamping the base.
  assign base_c   = CW'(clamp_min(32'(cnt_q), 32'(limit)));
  assign limit_p1 = CW'(limit) + CW'(1);
  // A step larger than the whole range behaves as exactly one full lap.
  assign step_s   = CW'(clamp_min(32'(step), 32'(limit_p1)));

  step_unit #(
    .width (width)
  ) u_step_unit (
    .c_i     (base_c),
    .s_i     (step_s),
    .limit_i (limit),
    .up_i    (up),
    .sat_i   (sat),
    .next_o  (step_next),
    .ovf_o   (step_ovf)
  );

  always_comb begin
    cnt_d = cnt_q;
    evt_d = 1'b0;
    ovf_d = ovf_q;
    if (load) begin
      cnt_d = width'(clamp_min(32'(cnt_in), 32'(limit)));
      ovf_d = 1'b0;
    end else if (enab) begin
      cnt_d = step_next;
      evt_d = step_ovf;
      ovf_d = ovf_q | step_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      evt_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      evt_q <= evt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_out = cnt_q;
  assign evt     = evt_q;
  assign ovf     = ovf_q;
  assign at_end  = (up == DIR_UP) ? (cnt_q == limit) : (cnt_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter (width=5, step_w=2).
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst, load, enab, up, sat;
  logic [1:0] step;
  logic [4:0] limit, cnt_in;
  logic [4:0] cnt_out;
  logic       evt, ovf, at_end;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_counter #(
    .width  (5),
    .step_w (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .enab    (enab),
    .up      (up),
    .sat     (sat),
    .step    (step),
    .limit   (limit),
    .cnt_in  (cnt_in),
    .cnt_out (cnt_out),
    .evt     (evt),
    .ovf     (ovf),
    .at_end  (at_end)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int c, input int e, input int o);
    chk({tag, ".cnt"}, 32'(cnt_out), 32'(c));
    chk({tag, ".evt"}, 32'(evt), 32'(e));
    chk({tag, ".ovf"}, 32'(ovf), 32'(o));
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; enab = 1'b0; up = 1'b1; sat = 1'b0;
    step = 2'd0; limit = 5'd20; cnt_in = 5'd0;
    tick();
    chk_state("reset", 0, 0, 0);
    chk("reset.at_end", 32'(at_end), 0);

    // Load above limit clamps
    rst = 1'b0; load = 1'b1; cnt_in = 5'd25;
    tick();
    chk_state("load_clamp", 20, 0, 0);
    chk("load_clamp.at_end", 32'(at_end), 1);

    // Up wrap: 8 -> 1 -> 4
    limit = 5'd9; cnt_in = 5'd8;
    tick();
    load = 1'b0; enab = 1'b1; up = 1'b1; sat = 1'b0; step = 2'd3;
    tick();
    chk_state("upwrap1", 1, 1, 1);
    tick();
    chk_state("upwrap2", 4, 0, 1);

    // Down saturate from 1
    enab = 1'b0; load = 1'b1; cnt_in = 5'd1;
    tick();
    chk_state("load1", 1, 0, 0);
    load = 1'b0; enab = 1'b1; up = 1'b0; sat = 1'b1; step = 2'd2;
    tick();
    chk_state("dnsat1", 0, 1, 1);
    tick();
    chk_state("dnsat2", 0, 1, 1);
    chk("dnsat.at_end", 32'(at_end), 1);

    // Hold drops evt, keeps ovf
    enab = 1'b0;
    tick();
    chk_state("hold", 0, 0, 1);

    // Load with enab: step ignored, ovf cleared
    load = 1'b1; enab = 1'b1; up = 1'b1; step = 2'd3; cnt_in = 5'd5;
    tick();
    chk_state("load_enab", 5, 0, 0);

    // Limit lowered below count: 15, limit 7, up 1 wrap -> 0
    enab = 1'b0; limit = 5'd20; cnt_in = 5'd15;
    tick();
    load = 1'b0; enab = 1'b1; limit = 5'd7; up = 1'b1; sat = 1'b0; step = 2'd1;
    tick();
    chk_state("limit_drop", 0, 1, 1);

    // limit=0: every nonzero step flags
    limit = 5'd0;
    tick();
    chk_state("lim0_a", 0, 1, 1);
    up = 1'b0;
    tick();
    chk_state("lim0_b", 0, 1, 1);

    // Full range wrap: 30 + 3 -> 1
    enab = 1'b0; load = 1'b1; limit = 5'd31; cnt_in = 5'd30;
    tick();
    load = 1'b0; enab = 1'b1; up = 1'b1; sat = 1'b0; step = 2'd3;
    tick();
    chk_state("full_wrap", 1, 1, 1);

    // Step 0 holds
    step = 2'd0;
    tick();
    chk_state("step0", 1, 0, 1);

    // Up saturate at 9 holds and keeps pulsing
    enab = 1'b0; load = 1'b1; limit = 5'd9; cnt_in = 5'd8;
    tick();
    load = 1'b0; enab = 1'b1; up = 1'b1; sat = 1'b1; step = 2'd3;
    tick();
    chk_state("upsat1", 9, 1, 1);
    tick();
    chk_state("upsat2", 9, 1, 1);

    // Down wrap: 1 - 3 in 0..9 -> 8
    enab = 1'b0; load = 1'b1; cnt_in = 5'd1;
    tick();
    load = 1'b0; enab = 1'b1; up = 1'b0; sat = 1'b0; step = 2'd3;
    tick();
    chk_state("dnwrap", 8, 1, 1);
    chk("dnwrap.at_end", 32'(at_end), 0);

    // Step clamped to limit+1: range 0..1, step 3 from 0 is one lap -> 0
    enab = 1'b0; load = 1'b1; limit = 5'd1; cnt_in = 5'd0;
    tick();
    load = 1'b0; enab = 1'b1; up = 1'b1; sat = 1'b0; step = 2'd3;
    tick();
    chk_state("step_clamp", 0, 1, 1);

    // Plain up count without overflow
    limit = 5'd20; step = 2'd2;
    tick();
    chk_state("plain_up", 2, 0, 1);

    // Reset beats load and enab
    rst = 1'b1; load = 1'b1; cnt_in = 5'd7;
    tick();
    chk_state("rst_mid", 0, 0, 0);
    rst = 1'b0; load = 1'b0; enab = 1'b0;
    tick();
    chk_state("post_rst", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
